// File: rtl/pmp_csr_regs_if.sv
// CSR access bus between the core's CSR decode/write path and the PMP register file.
interface pmp_csr_regs_if;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;

    modport master (
        output csr_we_i,
        output csr_addr_i,
        output csr_wdata_i,
        input  csr_rdata_o,
        input  csr_hit_o
    );

    modport slave (
        input  csr_we_i,
        input  csr_addr_i,
        input  csr_wdata_i,
        output csr_rdata_o,
        output csr_hit_o
    );
endinterface

// File: rtl/pmp_csr_regs.sv
// Machine-mode PMP CSR register file: pmpcfg/pmpaddr/mseccfg storage with WARL
// legalisation and lock rules, driving packed buses for the PMP access checker.
module pmp_csr_regs #(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    pmp_csr_regs_if.slave                 csr,
    output logic [PMPNumRegions*6-1:0]    pmp_cfg_o,
    output logic [PMPNumRegions*34-1:0]   pmp_addr_o,
    output logic [2:0]                    pmp_mseccfg_o
);

    localparam int G = int'(PMPGranularity);
    localparam int NR = int'(PMPNumRegions);

    localparam logic [1:0] A_OFF   = 2'b00;
    localparam logic [1:0] A_TOR   = 2'b01;
    localparam logic [1:0] A_NA4   = 2'b10;
    localparam logic [1:0] A_NAPOT = 2'b11;

    typedef struct packed {
        logic       l;
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } cfg_t;

    function automatic logic [31:0] low_ones(input int n);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < n) m[b] = 1'b1;
        end
        return m;
    endfunction

    // Bits below G-1 are not stored; NAPOT reads fill [G-2:0] with ones;
    // OFF/TOR reads clear [G-1:0]. All masks collapse to zero when G=0.
    localparam logic [31:0] ADDR_WMASK = ~low_ones(G - 1);
    localparam logic [31:0] NAPOT_ONES = low_ones(G - 1);
    localparam logic [31:0] TOR_CLR    = low_ones(G);

    // Takes {L, A[1:0], X, W, R}; reserved bits never reach storage.
    function automatic cfg_t legal_cfg(input logic [5:0] raw, input logic mml);
        cfg_t c;
        c = cfg_t'(raw);
        if (!mml && c.w && !c.r) c.w = 1'b0;
        if ((G >= 1) && (c.a == A_NA4)) c.a = A_OFF;
        return c;
    endfunction

    cfg_t        cfg_q  [NR];
    cfg_t        cfg_d  [NR];
    logic [31:0] addr_q [NR];
    logic [31:0] addr_d [NR];
    logic [31:0] addr_rd[NR];
    logic        mml_q, mmwp_q, rlb_q;
    logic        mml_d, mmwp_d, rlb_d;

    logic [NR-1:0] entry_locked;
    logic [NR-1:0] addr_locked;
    logic [NR:0]   tor_lock_above;
    logic          any_l;

    // Lock state derived from pre-write contents.
    always_comb begin
        tor_lock_above     = '0;
        entry_locked       = '0;
        addr_locked        = '0;
        any_l              = 1'b0;
        for (int i = 0; i < NR; i++) begin
            tor_lock_above[i] = cfg_q[i].l && (cfg_q[i].a == A_TOR);
            entry_locked[i]   = cfg_q[i].l && !rlb_q;
            any_l             = any_l | cfg_q[i].l;
        end
        for (int i = 0; i < NR; i++) begin
            addr_locked[i] = entry_locked[i] || (tor_lock_above[i+1] && !rlb_q);
        end
    end

    // Read view of pmpaddr, shaped by the region's address-matching mode.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            addr_rd[i] = addr_q[i];
            if (cfg_q[i].a == A_NAPOT) begin
                addr_rd[i] = addr_q[i] | NAPOT_ONES;
            end else if (!cfg_q[i].a[1]) begin
                addr_rd[i] = addr_q[i] & ~TOR_CLR;
            end
        end
    end

    // Next-state computation for a CSR write, legalised per byte / per field.
    always_comb begin
        logic [7:0] wbyte;
        cfg_t       wcfg;
        logic       drop;
        mml_d  = mml_q;
        mmwp_d = mmwp_q;
        rlb_d  = rlb_q;
        for (int i = 0; i < NR; i++) begin
            cfg_d[i]  = cfg_q[i];
            addr_d[i] = addr_q[i];
            wbyte     = csr.csr_wdata_i[8*(i%4) +: 8];
            wcfg      = legal_cfg({wbyte[7], wbyte[4:0]}, mml_q);
            drop      = mml_q && !rlb_q && wbyte[7] && wbyte[2];
            if (csr.csr_we_i && (csr.csr_addr_i == (12'h3A0 + 12'(i / 4)))
                    && !entry_locked[i] && !drop) begin
                cfg_d[i] = wcfg;
            end
            if (csr.csr_we_i && (csr.csr_addr_i == (12'h3B0 + 12'(i)))
                    && !addr_locked[i]) begin
                addr_d[i] = csr.csr_wdata_i & ADDR_WMASK;
            end
        end
        if (csr.csr_we_i && (csr.csr_addr_i == 12'h747)) begin
            mml_d  = mml_q  | csr.csr_wdata_i[0];
            mmwp_d = mmwp_q | csr.csr_wdata_i[1];
            if (rlb_q || !any_l) rlb_d = csr.csr_wdata_i[2];
        end
    end

    // State registers; reset wins over a coincident write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
            mml_q  <= 1'b0;
            mmwp_q <= 1'b0;
            rlb_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                cfg_q[i]  <= cfg_d[i];
                addr_q[i] <= addr_d[i];
            end
            mml_q  <= mml_d;
            mmwp_q <= mmwp_d;
            rlb_q  <= rlb_d;
        end
    end

    // Combinational CSR read and address decode; unimplemented regions hit but read 0.
    always_comb begin
        csr.csr_rdata_o = '0;
        csr.csr_hit_o   = 1'b0;
        if (csr.csr_addr_i[11:2] == 10'h0E8) begin
            csr.csr_hit_o = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (csr.csr_addr_i == (12'h3A0 + 12'(i / 4))) begin
                    csr.csr_rdata_o[8*(i%4) +: 8] = {cfg_q[i].l, 2'b00, cfg_q[i].a,
                                                     cfg_q[i].x, cfg_q[i].w, cfg_q[i].r};
                end
            end
        end else if (csr.csr_addr_i[11:4] == 8'h3B) begin
            csr.csr_hit_o = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (csr.csr_addr_i[3:0] == 4'(i)) csr.csr_rdata_o = addr_rd[i];
            end
        end else if (csr.csr_addr_i == 12'h747) begin
            csr.csr_hit_o   = 1'b1;
            csr.csr_rdata_o = {29'b0, rlb_q, mmwp_q, mml_q};
        end else if (csr.csr_addr_i == 12'h757) begin
            csr.csr_hit_o = 1'b1;
        end
    end

    // Checker-facing buses, region 0 in the most-significant slice.
    for (genvar gi = 0; gi < NR; gi++) begin : g_out
        assign pmp_cfg_o[(NR-1-gi)*6 +: 6]   = cfg_q[gi];
        assign pmp_addr_o[(NR-1-gi)*34 +: 34] = {addr_rd[gi], 2'b00};
    end

    assign pmp_mseccfg_o = {rlb_q, mmwp_q, mml_q};

endmodule

// File: tb/tb_pmp_csr_regs.sv
// Self-checking bench: two register files (G=0 and G=2); CSR read expectations
// go through a scoreboard queue, bus checks are compared directly.
module tb_pmp_csr_regs;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    pmp_csr_regs_if bus0 ();
    pmp_csr_regs_if bus2 ();

    logic [23:0]  cfg0, cfg2;
    logic [135:0] addr0, addr2;
    logic [2:0]   msec0, msec2;

    pmp_csr_regs #(.PMPGranularity(0), .PMPNumRegions(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .csr(bus0.slave),
        .pmp_cfg_o(cfg0), .pmp_addr_o(addr0), .pmp_mseccfg_o(msec0)
    );

    pmp_csr_regs #(.PMPGranularity(2), .PMPNumRegions(4)) dut_g2 (
        .clk_i(clk_i), .rst_i(rst_i), .csr(bus2.slave),
        .pmp_cfg_o(cfg2), .pmp_addr_o(addr2), .pmp_mseccfg_o(msec2)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        bit          sel;
        logic [31:0] rdata;
        logic        hit;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   rd_vld = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic we, input logic [11:0] a, input logic [31:0] d);
        if (sel) begin
            bus2.csr_we_i = we; bus2.csr_addr_i = a; bus2.csr_wdata_i = d;
        end else begin
            bus0.csr_we_i = we; bus0.csr_addr_i = a; bus0.csr_wdata_i = d;
        end
    endtask

    task automatic wr(input bit sel, input logic [11:0] a, input logic [31:0] d);
        drive(sel, 1'b1, a, d);
        @(posedge clk_i); #1;
        drive(sel, 1'b0, a, 32'h0);
    endtask

    task automatic rd(input string tag, input bit sel, input logic [11:0] a,
                      input logic [31:0] exp, input logic hit);
        exp_t e;
        drive(sel, 1'b0, a, 32'h0);
        e.tag = tag; e.sel = sel; e.rdata = exp; e.hit = hit;
        sb_q.push_back(e);
        rd_vld = 1'b1;
        @(posedge clk_i); #1;
        rd_vld = 1'b0;
    endtask

    // Read in the same cycle as a write: must observe the pre-write value.
    task automatic wr_rd(input string tag, input bit sel, input logic [11:0] a,
                         input logic [31:0] d, input logic [31:0] exp_old);
        exp_t e;
        drive(sel, 1'b1, a, d);
        e.tag = tag; e.sel = sel; e.rdata = exp_old; e.hit = 1'b1;
        sb_q.push_back(e);
        rd_vld = 1'b1;
        @(posedge clk_i); #1;
        rd_vld = 1'b0;
        drive(sel, 1'b0, a, 32'h0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    // Monitor: pop one expectation per read cycle, sampled mid-cycle.
    always @(negedge clk_i) begin
        exp_t e;
        if (rd_vld) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk(e.tag, e.sel ? bus2.csr_rdata_o : bus0.csr_rdata_o, e.rdata);
                chk({e.tag, "_hit"}, e.sel ? bus2.csr_hit_o : bus0.csr_hit_o, e.hit);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 12'h0, 32'h0);
        drive(1'b1, 1'b0, 12'h0, 32'h0);
        @(posedge clk_i); #1;
        do_reset();

        // Reset state
        rd("rst_cfg0", 0, 12'h3A0, 32'h0, 1'b1);
        rd("rst_addr0", 0, 12'h3B0, 32'h0, 1'b1);
        rd("rst_msec", 0, 12'h747, 32'h0, 1'b1);
        rd("miss_3a4", 0, 12'h3A4, 32'h0, 1'b0);
        rd("miss_746", 0, 12'h746, 32'h0, 1'b0);
        rd("hit_757", 0, 12'h757, 32'h0, 1'b1);
        chk("rst_cfg_bus", 64'(cfg0), 64'h0);
        chk("rst_addr_bus", 64'(addr0[67:0]), 64'h0);
        chk("rst_msec_bus", 64'(msec0), 64'h0);
        chk("rst_g2_cfg_bus", 64'(cfg2), 64'h0);

        // W without R cleared when MML=0; same-cycle read sees old value
        wr_rd("wr_old", 0, 12'h3A0, 32'h0000_000A, 32'h0);
        rd("wr_wnr", 0, 12'h3A0, 32'h0000_0008, 1'b1);
        chk("wnr_cfg_bus", 64'(cfg0), 64'h20_0000);
        wr(0, 12'h747, 32'h1);
        rd("mml_set", 0, 12'h747, 32'h1, 1'b1);
        wr(0, 12'h3A0, 32'h0000_000A);
        rd("wnr_mml", 0, 12'h3A0, 32'h0000_000A, 1'b1);

        // Locked region1 TOR protects pmpaddr0 and pmpaddr1 from the very next cycle
        do_reset();
        wr(0, 12'h3A0, 32'h0000_8D00);
        wr(0, 12'h3B0, 32'h0000_1234);
        wr(0, 12'h3B1, 32'h0000_5678);
        wr(0, 12'h3B2, 32'h0000_ABCD);
        rd("tor_lk_addr0", 0, 12'h3B0, 32'h0, 1'b1);
        rd("lk_addr1", 0, 12'h3B1, 32'h0, 1'b1);
        rd("free_addr2", 0, 12'h3B2, 32'h0000_ABCD, 1'b1);
        chk("addr2_bus", 64'(addr0[67:34]), 64'({32'h0000_ABCD, 2'b00}));
        wr(0, 12'h3A0, 32'h0000_0F01);
        rd("lk_byte1", 0, 12'h3A0, 32'h0000_8D01, 1'b1);
        chk("lk_cfg_bus", 64'(cfg0), 64'h06_D000);

        // RLB blocked by a locked region; accepted when set first
        do_reset();
        wr(0, 12'h3A0, 32'h0000_0080);
        wr(0, 12'h747, 32'h4);
        rd("rlb_blocked", 0, 12'h747, 32'h0, 1'b1);
        wr(0, 12'h3A0, 32'h0);
        rd("lk_cfg_kept", 0, 12'h3A0, 32'h0000_0080, 1'b1);
        do_reset();
        wr(0, 12'h747, 32'h4);
        rd("rlb_set", 0, 12'h747, 32'h4, 1'b1);
        wr(0, 12'h3A0, 32'h0000_0080);
        wr(0, 12'h3A0, 32'h0);
        rd("rlb_unlock", 0, 12'h3A0, 32'h0, 1'b1);

        // Sticky MML/MMWP; L+X dropped per byte under MML without RLB
        do_reset();
        wr(0, 12'h747, 32'h3);
        wr(0, 12'h747, 32'h0);
        rd("sticky", 0, 12'h747, 32'h3, 1'b1);
        chk("sticky_bus", 64'(msec0), 64'h3);
        wr(0, 12'h3A0, 32'h199C_0000);
        rd("lx_drop", 0, 12'h3A0, 32'h1900_0000, 1'b1);
        wr(0, 12'h757, 32'hFFFF_FFFF);
        rd("mseccfgh", 0, 12'h757, 32'h0, 1'b1);

        // Unimplemented regions
        wr(0, 12'h3A1, 32'hFFFF_FFFF);
        rd("unimpl_cfg", 0, 12'h3A1, 32'h0, 1'b1);
        wr(0, 12'h3B4, 32'h1);
        rd("unimpl_addr", 0, 12'h3B4, 32'h0, 1'b1);

        // Reset dominates a coincident write
        wr(0, 12'h3B2, 32'h77);
        drive(0, 1'b1, 12'h3B2, 32'h55);
        do_reset();
        drive(0, 1'b0, 12'h0, 32'h0);
        rd("rst_dom", 0, 12'h3B2, 32'h0, 1'b1);

        // Granularity 2
        wr(1, 12'h3B0, 32'hFFFF_FFFF);
        wr(1, 12'h3A0, 32'h0000_0018);
        rd("g2_napot", 1, 12'h3B0, 32'hFFFF_FFFF, 1'b1);
        chk("g2_napot_bus", 64'(addr2[135:102]), 64'h3_FFFF_FFFC);
        wr(1, 12'h3A0, 32'h0000_0008);
        rd("g2_tor", 1, 12'h3B0, 32'hFFFF_FFFC, 1'b1);
        wr(1, 12'h3A0, 32'h0000_0010);
        rd("g2_na4_cfg", 1, 12'h3A0, 32'h0, 1'b1);
        rd("g2_off_addr", 1, 12'h3B0, 32'hFFFF_FFFC, 1'b1);
        chk("g2_off_bus", 64'(addr2[135:102]), 64'h3_FFFF_FFF0);

        chk("sb_drained", 64'(sb_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
